// File: rtl/cmd_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cmd_rx -- serial command frame receiver
//
// Receives 48-bit command frames on a single serial line, MSB first, one bit
// per rising clock edge:
//   start(0) | transmission(1) | index[5:0] | arg[31:0] | crc7[6:0] | end(1)
// A CRC7 (x^7 + x^3 + 1, init 0) is computed over the first 40 bits and
// compared against the received CRC field.
//
// Parameters
//   CRC_EN           1: CRC7 is checked; 0: CRC field is captured but never
//                    flagged, and a frame with a good end bit is accepted.
//
// Ports
//   iClock           single clock, all state changes on its rising edge
//   Reset            synchronous, active-low reset
//   iCmd             serial command line, idles high
//   oArg[31:0]       argument of the last good frame (held)
//   oIndex[5:0]      command index of the last good frame (held)
//   oValid           one-cycle pulse: good frame received
//   oCrcErr          one-cycle pulse: CRC7 mismatch
//   oFrameErr        one-cycle pulse: bad transmission bit or end bit
//   oBusy            high while a frame is in progress (any state but IDLE)
//   pasee_por_reset  sticky flag, set once Reset has been seen low
// -----------------------------------------------------------------------------
module cmd_rx #(
    parameter int CRC_EN = 1
) (
    input  logic        iClock,
    input  logic        Reset,
    input  logic        iCmd,
    output logic [31:0] oArg,
    output logic [5:0]  oIndex,
    output logic        oValid,
    output logic        oCrcErr,
    output logic        oFrameErr,
    output logic        oBusy,
    output logic        pasee_por_reset
);

    // FSM encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_TXB  = 3'd1;
    localparam logic [2:0] ST_BODY = 3'd2;
    localparam logic [2:0] ST_CRC  = 3'd3;
    localparam logic [2:0] ST_ENDB = 3'd4;

    // Last bit position inside BODY (index + arg = 38 bits) and CRC (7 bits)
    localparam logic [5:0] BODY_LAST = 6'd37;
    localparam logic [5:0] CRC_LAST  = 6'd6;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [5:0]  bit_cnt;
    logic [37:0] body_sr;    // {index[5:0], arg[31:0]} as it arrives
    logic [6:0]  crc_rx;     // CRC field as received
    logic [6:0]  crc_calc;   // running CRC over start..arg
    logic        crc_ok;
    logic        end_ok;

    // One serial step of CRC7, generator x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb        = din ^ crc[6];
        crc7_step = {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    // Both fields are complete by the time ENDB is reached.
    assign crc_ok = (crc_rx == crc_calc) || (CRC_EN == 0);
    assign end_ok = iCmd;

    assign oBusy = (state != ST_IDLE);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!iCmd) state_nxt = ST_TXB;
            end
            ST_TXB: begin
                state_nxt = iCmd ? ST_BODY : ST_IDLE;
            end
            ST_BODY: begin
                if (bit_cnt == BODY_LAST) state_nxt = ST_CRC;
            end
            ST_CRC: begin
                if (bit_cnt == CRC_LAST) state_nxt = ST_ENDB;
            end
            ST_ENDB: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status pulses
    always_ff @(posedge iClock) begin
        if (!Reset) begin
            state           <= ST_IDLE;
            bit_cnt         <= 6'd0;
            body_sr         <= 38'd0;
            crc_rx          <= 7'd0;
            crc_calc        <= 7'd0;
            oArg            <= 32'd0;
            oIndex          <= 6'd0;
            oValid          <= 1'b0;
            oCrcErr         <= 1'b0;
            oFrameErr       <= 1'b0;
            pasee_por_reset <= 1'b1;
        end else begin
            state     <= state_nxt;
            oValid    <= 1'b0;
            oCrcErr   <= 1'b0;
            oFrameErr <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // The start bit is the first CRC input; seeding from 0
                    // every idle cycle means a new frame always starts clean.
                    bit_cnt  <= 6'd0;
                    crc_calc <= crc7_step(7'd0, iCmd);
                end

                ST_TXB: begin
                    bit_cnt  <= 6'd0;
                    crc_calc <= crc7_step(crc_calc, iCmd);
                    if (!iCmd) oFrameErr <= 1'b1;
                end

                ST_BODY: begin
                    body_sr  <= {body_sr[36:0], iCmd};
                    crc_calc <= crc7_step(crc_calc, iCmd);
                    bit_cnt  <= (bit_cnt == BODY_LAST) ? 6'd0 : bit_cnt + 6'd1;
                end

                ST_CRC: begin
                    crc_rx  <= {crc_rx[5:0], iCmd};
                    bit_cnt <= (bit_cnt == CRC_LAST) ? 6'd0 : bit_cnt + 6'd1;
                end

                ST_ENDB: begin
                    bit_cnt <= 6'd0;
                    if (end_ok && crc_ok) begin
                        oValid <= 1'b1;
                        oIndex <= body_sr[37:32];
                        oArg   <= body_sr[31:0];
                    end
                    // Faults are reported independently so a frame with both
                    // a bad end bit and a bad CRC raises both pulses.
                    if (!end_ok) oFrameErr <= 1'b1;
                    if (!crc_ok) oCrcErr   <= 1'b1;
                end

                default: begin
                    bit_cnt <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/cmd_rx.md
CMD_RX -- requirements
Module: cmd_rx

Interface
- REQ-001: Parameter CRC_EN, default 1, meaning: 1 = CRC7 checked; 0 = CRC field captured but oCrcErr held 0.
- REQ-002: iClock  input  1  single clock; all state updates on rising edge.
- REQ-003: Reset  input  1  reset is synchronous and active-low.
- REQ-004: iCmd  input  1  serial command line; idle high, MSB first, one bit sampled per iClock rising edge.
- REQ-005: oArg  output  32  argument of last good frame; holds until the next good frame.
- REQ-006: oIndex  output  6  command index of last good frame; holds until the next good frame.
- REQ-007: oValid  output  1  one-cycle pulse: good frame received.
- REQ-008: oCrcErr  output  1  one-cycle pulse: CRC7 mismatch.
- REQ-009: oFrameErr  output  1  one-cycle pulse: bad transmission bit or end bit.
- REQ-010: oBusy  output  1  high while a frame is being received.
- REQ-011: pasee_por_reset  output  1  1 once Reset has been asserted at least once.

Function
- REQ-012: Frame is 48 bits: start(0), transmission(1), index[5:0], arg[31:0], crc7[6:0], end(1).
- REQ-013: FSM states are IDLE, TXB, BODY, CRC and ENDB.
- REQ-014: Transitions:
  - IDLE→TXB when iCmd=0.
  - TXB→BODY when iCmd=1; TXB→IDLE when iCmd=0.
  - BODY→CRC after 38 bits.
  - CRC→ENDB after 7 bits.
  - ENDB→IDLE unconditionally.
- REQ-015: A 6-bit bit counter tracks position in BODY/CRC; it resets to 0 on entry to each of those states.
- REQ-016: Index and argument bits are shifted into a 38-bit register in BODY; received CRC bits go into a 7-bit register in CRC.
- REQ-017: CRC7 uses polynomial x^7+x^3+1 with initial value 0, computed serially over the first 40 bits (start, transmission, index, arg).
- REQ-018: Outputs in the cycle after the ENDB bit is sampled, with FSM already in IDLE:
  - end=1 and CRC ok: oValid=1 and oArg/oIndex updated.
  - end=0: oFrameErr=1.
  - CRC mismatch and CRC_EN=1: oCrcErr=1.
  - Both end and CRC faults: oFrameErr and oCrcErr both pulse; oValid=0.
- REQ-019: Transmission bit = 0: oFrameErr pulses in the next cycle and the FSM is in IDLE; oArg/oIndex unchanged.
- REQ-020: Back-to-back frames with zero idle bits are accepted: a start bit sampled in the oValid cycle begins a new frame.
- REQ-021: oBusy is 1 in every cycle the FSM is in TXB, BODY, CRC or ENDB, and 0 in IDLE.
- REQ-022: oValid, oCrcErr and oFrameErr are registered; each is high for exactly one cycle per event.
- REQ-023: Latency from end-bit sample to oValid is exactly 1 cycle; start-bit sample to oValid is 48 cycles.
- REQ-024: iCmd high in IDLE causes no state change and no output activity.

Reset
- REQ-025: While Reset=0 at a rising edge: FSM=IDLE, counter=0, shift/CRC registers=0.
- REQ-026: While Reset=0 at a rising edge, outputs are oArg=0, oIndex=0, oValid=0, oCrcErr=0, oFrameErr=0, oBusy=0.
- REQ-027: pasee_por_reset is set to 1 in any cycle Reset=0 and stays 1 thereafter; it is never cleared.
- REQ-028: Reset asserted mid-frame aborts the frame without any oValid/oCrcErr/oFrameErr pulse.
- REQ-029: Reception resumes with the first iCmd=0 sampled after Reset returns high.

Verification
- REQ-030: Reset low 2 cycles, then frame 0x40_00000000_95 → pasee_por_reset=1; oValid pulse 48 cycles after start; oIndex=0, oArg=0x00000000; no error pulses.
- REQ-031: Frame 0x48_000001AA_87 → oValid=1 one cycle after end bit; oIndex=8, oArg=0x000001AA; oBusy high exactly 47 cycles.
- REQ-032: Frame 0x51_00000000_57 (CRC bit flipped) → oCrcErr pulse; oValid=0; oArg/oIndex retain previous values.
- REQ-033: Frame 0x40_00000000_94 (end bit 0) → oFrameErr=1; frame with transmission bit 0 → oFrameErr pulse 2 cycles after start sample, FSM back in IDLE.
- REQ-034: Two frames, CMD8 then CMD17 (0x51_00000000_55), back-to-back with zero idle bits → two oValid pulses 48 cycles apart; final oIndex=17, oArg=0x00000000.
- REQ-035: Reset asserted at bit 20 of a frame, then a clean CMD0 frame → no pulse for the aborted frame; CMD0 reports oValid with oIndex=0.
